vga_screen_mux: RTL
===================

# vga_screen_mux

Output stage between the screen generators and the VGA connector. It takes the shared VGA timing and two pixel streams: the play field and the game-over text screen. It selects one stream and switches only at frame boundaries, with a black interlude of a programmable number of frames. It also re-aligns sync with RGB to absorb the character-ROM read latency of the text path.

## Interface
- `RGB_LAG`, default 1: cycles by which both RGB inputs lag `hsync_in`/`vsync_in`; ascii_rom read latency is 1.
- `BLANK_FRAMES`, default 8: whole black frames inserted on every screen change; 0 means a direct switch.
- `clk` input, 1: pixel clock, shared with vga_sync.
- `reset` input, 1: synchronous, active-high.
- `hsync_in` input, 1: horizontal sync from vga_sync, used as-is.
- `vsync_in` input, 1: vertical sync from vga_sync; pulse is high-active.
- `play_rgb` input, 12: play-field pixel, {r,g,b} 4 bits each.
- `go_rgb` input, 12: game-over pixel, {r,g,b}.
- `game_over` input, 1: request switch to the game-over screen; level or pulse.
- `restart` input, 1: request return to play; a 1-cycle pulse is enough.
- `hsync` output, 1: aligned horizontal sync.
- `vsync` output, 1: aligned vertical sync.
- `red` output, 4: pixel red.
- `green` output, 4: pixel green.
- `blue` output, 4: pixel blue.
- `screen` output, 2: current FSM state encoding.
- `busy` output, 1: high in either blank state.

## Operation
- **Frame tick.** `vs_q` registers `vsync_in`. `frame_tick = vsync_in & ~vs_q`, a 1-cycle pulse at each vsync rising edge.
- **Request latches.** `go_pend` is set by `game_over` and `rs_pend` by `restart`.
  - A latch holds until consumed at a frame tick.
  - A new request arriving in the same cycle as the consuming tick is also consumed.
  - `rs_pend` is cleared whenever the state is not GAMEOVER: restarts are ignored outside game-over.
  - `go_pend` is cleared whenever the state is not PLAY.
- **FSM states:** PLAY=0, BLANK_TO_GO=1, GAMEOVER=2, BLANK_TO_PLAY=3.
  - PLAY: on a tick with `go_pend` (or `game_over` high that cycle), go to BLANK_TO_GO with `fcnt`=0. If `BLANK_FRAMES`=0, go directly to GAMEOVER.
  - BLANK_TO_GO: on each tick, `fcnt`++. On the tick where `fcnt`==`BLANK_FRAMES`-1, go to GAMEOVER.
  - GAMEOVER: on a tick with `rs_pend` or `restart`, go to BLANK_TO_PLAY (or directly to PLAY if `BLANK_FRAMES`=0).
  - BLANK_TO_PLAY: counts like BLANK_TO_GO, then goes to PLAY.
  - If `game_over` and `restart` are both pending in PLAY, `game_over` wins.
- **Frame counter.** `fcnt` width is `$clog2(BLANK_FRAMES+1)`, minimum 1. It resets to 0 on every state entry.
- **Pixel select.** PLAY passes `play_rgb`, GAMEOVER passes `go_rgb`, and both blank states output 12'h000.
  - Selection uses the state register value at the cycle the RGB sample is taken.
  - The state changes on the tick edge, during vsync, when RGB is already black. No mid-frame tearing is possible.
- **Reset mid-operation.** The FSM returns to PLAY, `fcnt`=0, both pending latches clear, and the whole delay line clears. The output stays black until the first valid RGB arrives.

## Timing
- Sync path: `hsync_in`/`vsync_in` pass through `RGB_LAG`+1 registers to `hsync`/`vsync`.
- RGB path: the selected RGB is registered once to `red`/`green`/`blue`. This aligns an input pixel to its sync sample.
- Total latency: `RGB_LAG`+1 cycles from sync input to output.
- All outputs are registered.
- Reset values: `hsync`=0, `vsync`=0, `red`=`green`=`blue`=0, `screen`=0 (PLAY), `busy`=0.
- State update occurs in the cycle after the `vsync_in` rising edge, when `vs_q` is still low. `screen` changes on that same edge.
- Request to switch: the first frame tick after the request latches. At worst, one frame plus `BLANK_FRAMES` frames until the new screen appears.

## Structure
- Shared package `vga_pkg`:
  - `RGB_W`=12
  - state encoding localparams `SCR_PLAY`, `SCR_BLANK_GO`, `SCR_GAMEOVER`, `SCR_BLANK_PLAY`
  - `BLACK`=12'h000
- One sub-module `sync_delay` (parameter `DEPTH`): the 2-bit shift register for `{hsync, vsync}` with synchronous clear.
- The FSM, request latches and RGB mux stay in the top level.

## Test plan
- **Reset and delay:** hold `reset` for 3 cycles, then toggle `hsync_in` with `RGB_LAG`=1. Expect `hsync` to follow after exactly 2 cycles, RGB=0 during reset, and `screen`=0.
- **Direct pass-through:** in PLAY, drive `play_rgb`=12'hF80. Expect {`red`,`green`,`blue`}=F,8,0 one cycle later, with `go_rgb` ignored.
- **Game-over sequence:** set `BLANK_FRAMES`=2 and pulse `game_over` mid-frame. Expect:
  - `screen` stays 0 until the next vsync rise;
  - then `screen`=1 and `busy`=1 with black output for 2 ticks;
  - then `screen`=2 and `go_rgb` output.
- **Restart:** in GAMEOVER, pulse `restart` for 1 cycle. Expect `screen`=3 at the next tick, then 0 after 2 more ticks. A `restart` pulsed in PLAY causes no transition.
- **Simultaneous requests:** in PLAY, assert `game_over` and `restart` in the same cycle. Expect the transition to `screen`=1 and no further restart.
- **Reset mid-blank:** assert `reset` while `screen`=1 and `fcnt`=1. Expect `screen`=0 the next cycle, with no transition at the following tick.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pixel width, screen state encoding and colour constants
package vga_pkg;

    localparam int RGB_W = 12;

    localparam logic [1:0] SCR_PLAY       = 2'd0;
    localparam logic [1:0] SCR_BLANK_GO   = 2'd1;
    localparam logic [1:0] SCR_GAMEOVER   = 2'd2;
    localparam logic [1:0] SCR_BLANK_PLAY = 2'd3;

    localparam logic [RGB_W-1:0] BLACK = 12'h000;

    typedef enum logic [1:0] {
        ST_PLAY       = SCR_PLAY,
        ST_BLANK_GO   = SCR_BLANK_GO,
        ST_GAMEOVER   = SCR_GAMEOVER,
        ST_BLANK_PLAY = SCR_BLANK_PLAY
    } scr_state_t;

    function automatic logic is_blank(input scr_state_t s);
        return (s == ST_BLANK_GO) || (s == ST_BLANK_PLAY);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - DEPTH-stage shift register for {hsync, vsync} with synchronous clear
//
// Ports:
//   clk   - pixel clock
//   clear - synchronous clear, active high; zeroes every stage
//   d     - {hsync, vsync} input
//   q     - {hsync, vsync} delayed by DEPTH cycles
module sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= 2'b00;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_screen_mux.sv
// rtl/vga_screen_mux.sv - frame-synchronous play/game-over screen selector with black interlude
//
// Ports:
//   clk, reset           - pixel clock, synchronous active-high reset
//   hsync_in, vsync_in   - raw sync from the timing generator
//   play_rgb, go_rgb     - {r,g,b} pixels, both RGB_LAG cycles behind sync
//   game_over, restart   - screen change requests (level or pulse)
//   hsync, vsync         - sync delayed RGB_LAG+1 cycles
//   red, green, blue     - selected pixel, registered once
//   screen               - current state encoding
//   busy                 - high while a blank interlude is running
module vga_screen_mux
    import vga_pkg::*;
#(
    parameter int RGB_LAG      = 1,
    parameter int BLANK_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [RGB_W-1:0] play_rgb,
    input  logic [RGB_W-1:0] go_rgb,
    input  logic             game_over,
    input  logic             restart,
    output logic             hsync,
    output logic             vsync,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic [1:0]       screen,
    output logic             busy
);

    localparam int FCNT_W    = ($clog2(BLANK_FRAMES + 1) > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam int FCNT_LAST = (BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0;
    localparam logic [FCNT_W-1:0] FCNT_END = FCNT_W'(FCNT_LAST);

    scr_state_t        state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              go_pend_q, go_pend_d;
    logic              rs_pend_q, rs_pend_d;
    logic              vs_q;
    logic              frame_tick;
    logic              busy_q;
    logic [RGB_W-1:0]  rgb_sel, rgb_q;
    logic [1:0]        sync_q;

    assign frame_tick = vsync_in & ~vs_q;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        // A request seen on the consuming tick is folded into that tick,
        // so the latch never survives a tick. Latches only live in the
        // state that can act on them.
        go_pend_d = (state_q == ST_PLAY) && !frame_tick && (go_pend_q || game_over);
        rs_pend_d = (state_q == ST_GAMEOVER) && !frame_tick && (rs_pend_q || restart);

        if (frame_tick) begin
            case (state_q)
                ST_PLAY: begin
                    if (go_pend_q || game_over) begin
                        state_d = (BLANK_FRAMES == 0) ? ST_GAMEOVER : ST_BLANK_GO;
                        fcnt_d  = '0;
                    end
                end
                ST_BLANK_GO: begin
                    if (fcnt_q == FCNT_END) begin
                        state_d = ST_GAMEOVER;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                ST_GAMEOVER: begin
                    if (rs_pend_q || restart) begin
                        state_d = (BLANK_FRAMES == 0) ? ST_PLAY : ST_BLANK_PLAY;
                        fcnt_d  = '0;
                    end
                end
                ST_BLANK_PLAY: begin
                    if (fcnt_q == FCNT_END) begin
                        state_d = ST_PLAY;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_PLAY;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        rgb_sel = BLACK;
        case (state_q)
            ST_PLAY:     rgb_sel = play_rgb;
            ST_GAMEOVER: rgb_sel = go_rgb;
            default:     rgb_sel = BLACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_PLAY;
            fcnt_q    <= '0;
            go_pend_q <= 1'b0;
            rs_pend_q <= 1'b0;
            vs_q      <= 1'b0;
            busy_q    <= 1'b0;
            rgb_q     <= BLACK;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            go_pend_q <= go_pend_d;
            rs_pend_q <= rs_pend_d;
            vs_q      <= vsync_in;
            busy_q    <= is_blank(state_d);
            rgb_q     <= rgb_sel;
        end
    end

    // RGB already trails sync by RGB_LAG; one extra stage on both paths
    // keeps them aligned at the connector.
    sync_delay #(
        .DEPTH(RGB_LAG + 1)
    ) u_sync_delay (
        .clk   (clk),
        .clear (reset),
        .d     ({hsync_in, vsync_in}),
        .q     (sync_q)
    );

    assign hsync  = sync_q[1];
    assign vsync  = sync_q[0];
    assign red    = rgb_q[11:8];
    assign green  = rgb_q[7:4];
    assign blue   = rgb_q[3:0];
    assign screen = state_q;
    assign busy   = busy_q;

endmodule
